// File: rtl/gsm_egress_pkg.sv
// Shared types and constants for the gsm_sys egress serializer.
//   - ser_state_e     : serializer FSM state encoding
//   - PKT_LEN_W       : width of the packet-length field in a packet's first cell
//   - DEF_LOC_PKT_LEN : default LSB position of that field
package gsm_egress_pkg;

    localparam int unsigned PKT_LEN_W       = 8;
    localparam int unsigned DEF_LOC_PKT_LEN = 24;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/gsm_egress_serializer_fifo.sv
// gsm_cell_fifo: DEPTH x DWIDTH synchronous cell FIFO.
// Ports:
//   clk_80M, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data      : write request and cell
//   rd_en, rd_data      : pop request and head-of-queue cell (show-ahead)
//   full, empty         : status flags
//   occupancy           : number of stored cells
// A write while full succeeds only when a pop happens in the same cycle.
module gsm_cell_fifo #(
    parameter int unsigned DWIDTH = 256,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned OW     = $clog2(DEPTH + 1)
) (
    input  logic              clk_80M,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [OW-1:0]     occupancy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Status and accepted-operation qualifiers
    always_comb begin
        full    = (occupancy == OW'(DEPTH));
        empty   = (occupancy == '0);
        rd_ok   = rd_en & ~empty;
        wr_ok   = wr_en & (~full | rd_ok);
        rd_data = mem[rd_ptr];
    end

    // Cell storage needs no reset; occupancy guards every read
    always_ff @(posedge clk_80M) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work
    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/gsm_egress_serializer.sv
// gsm_egress_serializer: buffers egress cells from gsm_sys and shifts them
// MSB-first onto a 1-bit line with start/end-of-packet markers.
// Ports:
//   clk_80M, rst_n  : clock, asynchronous active-low reset
//   i_valid, i_data : cell from gsm_sys egress port
//   o_stall         : registered backpressure to gsm_sys
//   i_pause         : downstream pause, holds the current bit
//   o_bit_valid     : o_bit carries a bit this cycle
//   o_bit           : serial data
//   o_sop, o_eop    : first / last bit of a packet
//   o_overflow      : one-cycle pulse when a cell was dropped on a full FIFO
module gsm_egress_serializer
    import gsm_egress_pkg::*;
#(
    parameter int unsigned DWIDTH      = 256,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned LOC_PKT_LEN = DEF_LOC_PKT_LEN,
    parameter int unsigned CWIDTH      = 8
) (
    input  logic              clk_80M,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_stall,
    input  logic              i_pause,
    output logic              o_bit_valid,
    output logic              o_bit,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_overflow
);

    localparam int unsigned OW = $clog2(DEPTH + 1);

    ser_state_e             state;
    logic [DWIDTH-1:0]      shifter;
    logic [CWIDTH-1:0]      bit_cnt;
    logic [PKT_LEN_W-1:0]   cells_left;
    logic                   first_flag;
    logic                   last_flag;

    logic [DWIDTH-1:0]      head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [OW-1:0]          occupancy;

    logic                   advance;
    logic                   last_bit;
    logic                   pop;
    logic [PKT_LEN_W-1:0]   head_len;
    logic [PKT_LEN_W-1:0]   start_len;

    gsm_cell_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .OW     (OW)
    ) u_fifo (
        .clk_80M   (clk_80M),
        .rst_n     (rst_n),
        .wr_en     (i_valid),
        .wr_data   (i_data),
        .rd_en     (pop),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // Shift/pop control and line outputs; valid follows pause without delay
    always_comb begin
        last_bit    = (bit_cnt == CWIDTH'(DWIDTH - 1));
        advance     = (state == SHIFT) & ~i_pause;
        pop         = ~fifo_empty & ((state == IDLE) | (advance & last_bit));
        head_len    = head[LOC_PKT_LEN +: PKT_LEN_W];
        // A zero length field still describes a one-cell packet
        start_len   = (head_len == '0) ? PKT_LEN_W'(1) : head_len;
        o_bit_valid = advance;
        o_bit       = (state == SHIFT) & shifter[DWIDTH-1];
        o_sop       = advance & first_flag & (bit_cnt == '0);
        o_eop       = advance & last_flag & last_bit;
    end

    // Serializer FSM, framing counters and registered status outputs
    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            cells_left <= '0;
            first_flag <= 1'b0;
            last_flag  <= 1'b0;
            o_stall    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            // Stall one cycle late; the spare FIFO slot absorbs the in-flight cell
            o_stall    <= (occupancy >= OW'(DEPTH - 1));
            o_overflow <= i_valid & fifo_full & ~pop;

            if (pop) begin
                state   <= SHIFT;
                shifter <= head;
                bit_cnt <= '0;
                if (cells_left == '0) begin
                    cells_left <= start_len - PKT_LEN_W'(1);
                    first_flag <= 1'b1;
                    last_flag  <= (start_len == PKT_LEN_W'(1));
                end else begin
                    cells_left <= cells_left - PKT_LEN_W'(1);
                    first_flag <= 1'b0;
                    last_flag  <= (cells_left == PKT_LEN_W'(1));
                end
            end else if (advance) begin
                shifter <= shifter << 1;
                bit_cnt <= bit_cnt + CWIDTH'(1);
                if (last_bit) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gsm_egress_serializer.sv
// Directed self-checking bench for gsm_egress_serializer (DWIDTH=256, DEPTH=2).
module tb_gsm_egress_serializer;

    localparam int unsigned DW = 256;

    logic          clk_80M = 1'b0;
    logic          rst_n   = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data  = '0;
    logic          i_pause = 1'b0;
    logic          o_stall;
    logic          o_bit_valid;
    logic          o_bit;
    logic          o_sop;
    logic          o_eop;
    logic          o_overflow;

    gsm_egress_serializer u_dut (
        .clk_80M     (clk_80M),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_stall     (o_stall),
        .i_pause     (i_pause),
        .o_bit_valid (o_bit_valid),
        .o_bit       (o_bit),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_overflow  (o_overflow)
    );

    always #6 clk_80M = ~clk_80M;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Line monitor: records every valid bit plus sop/eop positions and overflow pulses
    int   cyc = 0;
    logic mon_bits[$];
    int   sop_q[$];
    int   eop_q[$];
    int   first_cyc;
    int   last_cyc;
    int   ovf_cnt;
    int   ovf_cyc;

    always @(posedge clk_80M) cyc++;

    always begin
        @(negedge clk_80M);
        #2;
        if (o_bit_valid) begin
            if (mon_bits.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            if (o_sop) sop_q.push_back(mon_bits.size());
            if (o_eop) eop_q.push_back(mon_bits.size());
            mon_bits.push_back(o_bit);
        end
        if (o_overflow) begin
            ovf_cnt++;
            ovf_cyc = cyc;
        end
    end

    task automatic clear_mon();
        mon_bits.delete();
        sop_q.delete();
        eop_q.delete();
        first_cyc = -1;
        last_cyc  = -1;
        ovf_cnt   = 0;
        ovf_cyc   = -1;
    endtask

    function automatic logic [DW-1:0] make_cell(input logic [7:0] top, input logic [7:0] len,
                                                input logic [31:0] seed);
        logic [DW-1:0] c;
        c          = {8{seed}};
        c[DW-1 -: 8] = top;
        c[24 +: 8]   = len;
        return c;
    endfunction

    // Count of line bits that differ from the expected MSB-first cell stream
    function automatic int bit_errs(input logic [DW-1:0] cells[$]);
        int bad;
        int n;
        bad = 0;
        n   = cells.size() * DW;
        if (mon_bits.size() != n) bad++;
        for (int i = 0; i < n && i < mon_bits.size(); i++) begin
            if (mon_bits[i] !== cells[i / DW][DW - 1 - (i % DW)]) bad++;
        end
        return bad;
    endfunction

    task automatic wait_bits(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (mon_bits.size() < n && k < budget) begin
            @(negedge clk_80M);
            k++;
        end
        if (k >= budget) check({tag, "_timeout"}, 64'(mon_bits.size()), 64'(n));
        repeat (4) @(negedge clk_80M);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] c0, c1, c2, c3;
        logic [DW-1:0] exp_q[$];
        logic [7:0]    top8;
        int            wr;
        int            paused_valid;

        clear_mon();

        // Reset state
        repeat (3) @(negedge clk_80M);
        #1;
        check("rst_outputs", {58'b0, o_bit_valid, o_bit, o_sop, o_eop, o_stall, o_overflow}, 64'd0);
        check("rst_occupancy", 64'(u_dut.u_fifo.occupancy), 64'd0);
        @(negedge clk_80M);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_80M);

        // T1: single one-cell packet, 0xA5 top byte
        c0 = make_cell(8'hA5, 8'd1, 32'h1234_5678);
        @(negedge clk_80M);
        clear_mon();
        i_valid = 1'b1; i_data = c0; wr = cyc;
        @(negedge clk_80M);
        i_valid = 1'b0;
        wait_bits(256, 400, "t1");
        check("t1_nbits", 64'(mon_bits.size()), 64'd256);
        check("t1_latency", 64'(first_cyc - wr), 64'd2);
        top8 = '0;
        for (int i = 0; i < 8; i++) top8 = {top8[6:0], mon_bits[i]};
        check("t1_top_byte", 64'(top8), 64'hA5);
        exp_q = {c0};
        check("t1_bits", 64'(bit_errs(exp_q)), 64'd0);
        check("t1_sop_n", 64'(sop_q.size()), 64'd1);
        check("t1_sop_idx", 64'(sop_q[0]), 64'd0);
        check("t1_eop_n", 64'(eop_q.size()), 64'd1);
        check("t1_eop_idx", 64'(eop_q[0]), 64'd255);
        check("t1_contig", 64'(last_cyc - first_cyc + 1), 64'd256);

        // T2: three back-to-back cells of one 3-cell packet, stall timing
        c0 = make_cell(8'h3C, 8'd3, 32'hCAFE_0001);
        c1 = make_cell(8'h81, 8'd5, 32'h0BAD_F00D);
        c2 = make_cell(8'h42, 8'd7, 32'h5555_AAAA);
        @(negedge clk_80M);
        clear_mon();
        i_valid = 1'b1; i_data = c0; wr = cyc;
        #1 check("t2_stall_c0", 64'(o_stall), 64'd0);
        @(negedge clk_80M);
        i_data = c1;
        #1 check("t2_stall_c1", 64'(o_stall), 64'd0);
        @(negedge clk_80M);
        i_data = c2;
        #1 check("t2_stall_c2", 64'(o_stall), 64'd1);
        @(negedge clk_80M);
        i_valid = 1'b0;
        wait_bits(768, 1000, "t2");
        check("t2_nbits", 64'(mon_bits.size()), 64'd768);
        check("t2_latency", 64'(first_cyc - wr), 64'd2);
        check("t2_contig", 64'(last_cyc - first_cyc + 1), 64'd768);
        exp_q = {c0, c1, c2};
        check("t2_bits", 64'(bit_errs(exp_q)), 64'd0);
        check("t2_sop_n", 64'(sop_q.size()), 64'd1);
        check("t2_sop_idx", 64'(sop_q[0]), 64'd0);
        check("t2_eop_n", 64'(eop_q.size()), 64'd1);
        check("t2_eop_idx", 64'(eop_q[0]), 64'd767);
        check("t2_no_ovf", 64'(ovf_cnt), 64'd0);

        // T3: 10-cycle pause at bit 100
        c0 = make_cell(8'h5A, 8'd1, 32'h0F0F_3C3C);
        @(negedge clk_80M);
        clear_mon();
        i_valid = 1'b1; i_data = c0;
        @(negedge clk_80M);
        i_valid = 1'b0;
        repeat (101) @(negedge clk_80M);
        check("t3_bits_before_pause", 64'(mon_bits.size()), 64'd100);
        i_pause = 1'b1;
        paused_valid = 0;
        repeat (10) begin
            #1 if (o_bit_valid) paused_valid++;
            @(negedge clk_80M);
        end
        i_pause = 1'b0;
        check("t3_pause_valid", 64'(paused_valid), 64'd0);
        wait_bits(256, 400, "t3");
        check("t3_nbits", 64'(mon_bits.size()), 64'd256);
        exp_q = {c0};
        check("t3_bits", 64'(bit_errs(exp_q)), 64'd0);
        check("t3_span", 64'(last_cyc - first_cyc + 1), 64'd266);
        check("t3_eop_idx", 64'(eop_q[0]), 64'd255);

        // T4: paused line, cells pushed ignoring stall; the cell hitting a full FIFO is dropped
        c0 = make_cell(8'h11, 8'd1, 32'hA0A0_0001);
        c1 = make_cell(8'h22, 8'd1, 32'hB0B0_0002);
        c2 = make_cell(8'h33, 8'd1, 32'hC0C0_0003);
        c3 = make_cell(8'h44, 8'd1, 32'hD0D0_0004);
        @(negedge clk_80M);
        clear_mon();
        i_pause = 1'b1;
        i_valid = 1'b1; i_data = c0; wr = cyc;
        @(negedge clk_80M);
        i_data = c1;
        @(negedge clk_80M);
        i_data = c2;
        @(negedge clk_80M);
        i_data = c3;
        @(negedge clk_80M);
        i_valid = 1'b0;
        #1;
        check("t4_ovf_pulse", 64'(o_overflow), 64'd1);
        check("t4_occupancy", 64'(u_dut.u_fifo.occupancy), 64'd2);
        @(negedge clk_80M);
        #1 check("t4_ovf_clear", 64'(o_overflow), 64'd0);
        repeat (5) @(negedge clk_80M);
        check("t4_ovf_cnt", 64'(ovf_cnt), 64'd1);
        check("t4_ovf_cyc", 64'(ovf_cyc - wr), 64'd4);
        check("t4_no_bits_paused", 64'(mon_bits.size()), 64'd0);
        i_pause = 1'b0;
        wait_bits(768, 1000, "t4");
        repeat (300) @(negedge clk_80M);
        check("t4_nbits", 64'(mon_bits.size()), 64'd768);
        exp_q = {c0, c1, c2};
        check("t4_bits", 64'(bit_errs(exp_q)), 64'd0);
        check("t4_sop_n", 64'(sop_q.size()), 64'd3);

        // T5: zero length field behaves as a one-cell packet
        c0 = make_cell(8'h96, 8'd0, 32'h7777_1111);
        c1 = make_cell(8'h69, 8'd0, 32'h2468_ACE0);
        @(negedge clk_80M);
        clear_mon();
        i_valid = 1'b1; i_data = c0;
        @(negedge clk_80M);
        i_data = c1;
        @(negedge clk_80M);
        i_valid = 1'b0;
        wait_bits(512, 700, "t5");
        check("t5_nbits", 64'(mon_bits.size()), 64'd512);
        check("t5_sop_n", 64'(sop_q.size()), 64'd2);
        check("t5_sop1_idx", 64'(sop_q[1]), 64'd256);
        check("t5_eop_n", 64'(eop_q.size()), 64'd2);
        check("t5_eop0_idx", 64'(eop_q[0]), 64'd255);
        check("t5_eop1_idx", 64'(eop_q[1]), 64'd511);

        // T6: reset at bit 50 with a second cell queued
        c0 = make_cell(8'hF0, 8'd1, 32'h1357_9BDF);
        c1 = make_cell(8'h0F, 8'd1, 32'hFDB9_7531);
        c2 = make_cell(8'hC3, 8'd1, 32'h8421_1248);
        @(negedge clk_80M);
        clear_mon();
        i_valid = 1'b1; i_data = c0;
        @(negedge clk_80M);
        i_data = c1;
        @(negedge clk_80M);
        i_valid = 1'b0;
        repeat (50) @(negedge clk_80M);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {58'b0, o_bit_valid, o_bit, o_sop, o_eop, o_stall, o_overflow}, 64'd0);
        check("t6_rst_occupancy", 64'(u_dut.u_fifo.occupancy), 64'd0);
        check("t6_bits_before_rst", 64'(mon_bits.size()), 64'd50);
        @(negedge clk_80M);
        check("t6_no_eop", 64'(eop_q.size()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_80M);
        clear_mon();
        i_valid = 1'b1; i_data = c2;
        @(negedge clk_80M);
        i_valid = 1'b0;
        wait_bits(256, 400, "t6");
        repeat (20) @(negedge clk_80M);
        check("t6_nbits", 64'(mon_bits.size()), 64'd256);
        exp_q = {c2};
        check("t6_bits", 64'(bit_errs(exp_q)), 64'd0);
        check("t6_sop_idx", 64'(sop_q[0]), 64'd0);
        check("t6_sop_n", 64'(sop_q.size()), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
